// File: rtl/program_loader.sv
// Byte-stream program loader: assembles big-endian 28-bit words from a valid/ready
// byte stream, writes them sequentially into instruction RAM, and holds the core in reset until done.
module program_loader #(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iStart,
    input  logic [7:0]            iByte,
    input  logic                  iByteValid,
    output logic                  oByteReady,
    output logic                  oWriteEnable,
    output logic [ADDR_WIDTH-1:0] oWriteAddress,
    output logic [27:0]           oWriteData,
    output logic                  oCpuReset,
    output logic                  oDone,
    output logic                  oError
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0]   MAX_WORDS = 17'd1 << ADDR_WIDTH;
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERROR
    } state_t;

    state_t                  state_q, state_d;
    logic [15:0]             len_q, len_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [27:0]             asm_q, asm_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic                    ready_q, ready_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [27:0]             wdata_q, wdata_d;
    logic                    cpu_rst_q, cpu_rst_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic        accept_s, recv_s, timeout_s, last_word_s;
    logic [15:0] len_word_s;

    assign accept_s    = iByteValid && ready_q;
    assign recv_s      = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA);
    assign timeout_s   = recv_s && !accept_s && (tmo_q == TMO_LAST);
    assign len_word_s  = {len_q[15:8], iByte};
    assign last_word_s = (17'(idx_q) == ({1'b0, len_q} - 17'd1));

    // Next-state, datapath and next-output computation
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        if (recv_s) begin
            if (accept_s) begin
                tmo_d = {TW{1'b0}};
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = tmo_q;
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (iStart) begin
                    state_d = S_LEN_HI;
                    idx_d   = {ADDR_WIDTH{1'b0}};
                    cnt_d   = 2'd0;
                    tmo_d   = {TW{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            S_LEN_HI: begin
                if (accept_s) begin
                    len_d[15:8] = iByte;
                    state_d     = S_LEN_LO;
                end else if (timeout_s) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = state_q;
                end
            end
            S_LEN_LO: begin
                if (accept_s) begin
                    len_d = len_word_s;
                    if (len_word_s == 16'd0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, len_word_s} > MAX_WORDS) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = 2'd0;
                    end
                end else if (timeout_s) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = state_q;
                end
            end
            S_DATA: begin
                if (accept_s) begin
                    asm_d = {asm_q[19:0], iByte};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = state_q;
                    end
                end else if (timeout_s) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = state_q;
                end
            end
            S_WRITE: begin
                if (last_word_s) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + ADDR_WIDTH'(1);
                    cnt_d   = 2'd0;
                    state_d = S_DATA;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with state_q
        ready_d   = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) || (state_d == S_DATA);
        we_d      = (state_d == S_WRITE);
        cpu_rst_d = (state_d != S_DONE);
        done_d    = (state_d == S_DONE);
        error_d   = (state_d == S_ERROR);
        if (state_d == S_WRITE) begin
            waddr_d = idx_q;
            wdata_d = asm_d;
        end else begin
            waddr_d = waddr_q;
            wdata_d = wdata_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            len_q     <= 16'd0;
            idx_q     <= {ADDR_WIDTH{1'b0}};
            cnt_q     <= 2'd0;
            asm_q     <= 28'd0;
            tmo_q     <= {TW{1'b0}};
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= {ADDR_WIDTH{1'b0}};
            wdata_q   <= 28'd0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            asm_q     <= asm_d;
            tmo_q     <= tmo_d;
            ready_q   <= ready_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign oByteReady    = ready_q;
    assign oWriteEnable  = we_q;
    assign oWriteAddress = waddr_q;
    assign oWriteData    = wdata_q;
    assign oCpuReset     = cpu_rst_q;
    assign oDone         = done_q;
    assign oError        = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: stream loads, empty/oversize programs,
// timeout, gapped stream with ignored nibble, and reset in mid-load.
module tb_program_loader;

    localparam int AW = 10;
    localparam int T  = 1000;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          iStart = 1'b0;
    logic [7:0]    iByte = 8'd0;
    logic          iByteValid = 1'b0;
    logic          oByteReady, oWriteEnable, oCpuReset, oDone, oError;
    logic [AW-1:0] oWriteAddress;
    logic [27:0]   oWriteData;

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;
    int cyc = 0;
    logic [AW-1:0] log_addr [0:63];
    logic [27:0]   log_data [0:63];

    program_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
        .Clock(Clock), .Reset(Reset), .iStart(iStart), .iByte(iByte),
        .iByteValid(iByteValid), .oByteReady(oByteReady), .oWriteEnable(oWriteEnable),
        .oWriteAddress(oWriteAddress), .oWriteData(oWriteData), .oCpuReset(oCpuReset),
        .oDone(oDone), .oError(oError)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // Record every write strobe the way the instruction RAM would see it
    always @(negedge Clock) begin
        if (oWriteEnable) begin
            log_addr[wr_cnt[5:0]] <= oWriteAddress;
            log_data[wr_cnt[5:0]] <= oWriteData;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        iByte = b;
        iByteValid = 1'b1;
        while (!oByteReady && n < 50) begin
            tick();
            n++;
        end
        if (!oByteReady) chk("send_ready", {31'd0, oByteReady}, 32'd1);
        else tick();
    endtask

    task automatic send_gap(input logic [7:0] b);
        iByteValid = 1'b0;
        repeat ($urandom_range(0, 4)) tick();
        send(b);
    endtask

    task automatic chk_outs(input string tag, input logic rst, input logic dn, input logic er);
        chk({tag, "_cpurst"}, {31'd0, oCpuReset}, {31'd0, rst});
        chk({tag, "_done"},   {31'd0, oDone},     {31'd0, dn});
        chk({tag, "_error"},  {31'd0, oError},    {31'd0, er});
    endtask

    initial begin
        int base;
        int c0;

        // Reset state
        repeat (2) tick();
        Reset = 1'b0;
        tick();
        chk_outs("reset", 1'b1, 1'b0, 1'b0);
        chk("reset_ready", {31'd0, oByteReady}, 32'd0);
        chk("reset_we", {31'd0, oWriteEnable}, 32'd0);
        chk("reset_addr", 32'(oWriteAddress), 32'd0);
        chk("reset_data", 32'(oWriteData), 32'd0);

        // Two-word program, valid held high
        base = wr_cnt;
        start();
        c0 = cyc;
        chk("lenhi_ready", {31'd0, oByteReady}, 32'd1);
        send(8'h00); send(8'h02);
        send(8'h0A); send(8'h12); send(8'h34); send(8'h56);
        chk("w0_we", {31'd0, oWriteEnable}, 32'd1);
        chk("w0_addr", 32'(oWriteAddress), 32'd0);
        chk("w0_data", 32'(oWriteData), 32'h0A123456);
        chk("w0_ready", {31'd0, oByteReady}, 32'd0);
        send(8'h01); send(8'h00); send(8'h00); send(8'h05);
        chk("w1_we", {31'd0, oWriteEnable}, 32'd1);
        chk("w1_addr", 32'(oWriteAddress), 32'd1);
        chk("w1_data", 32'(oWriteData), 32'h01000005);
        chk("w1_cpurst", {31'd0, oCpuReset}, 32'd1);
        iByteValid = 1'b0;
        tick();
        chk_outs("load2", 1'b0, 1'b1, 1'b0);
        chk("load2_we", {31'd0, oWriteEnable}, 32'd0);
        chk("load2_cycles", 32'(cyc - c0), 32'd12);
        chk("load2_hold_addr", 32'(oWriteAddress), 32'd1);
        chk("load2_hold_data", 32'(oWriteData), 32'h01000005);
        chk("load2_writes", 32'(wr_cnt - base), 32'd2);

        // Empty program from DONE
        base = wr_cnt;
        start();
        chk_outs("restart", 1'b1, 1'b0, 1'b0);
        send(8'h00); send(8'h00);
        iByteValid = 1'b0;
        chk_outs("empty", 1'b0, 1'b1, 1'b0);
        tick();
        chk("empty_writes", 32'(wr_cnt - base), 32'd0);

        // Oversize program: N = 1025
        base = wr_cnt;
        start();
        send(8'h04); send(8'h01);
        iByteValid = 1'b0;
        chk_outs("oversize", 1'b1, 1'b0, 1'b1);
        chk("oversize_ready", {31'd0, oByteReady}, 32'd0);
        tick();
        chk("oversize_writes", 32'(wr_cnt - base), 32'd0);

        // Timeout with a partial word
        base = wr_cnt;
        start();
        chk("tmo_restart_err", {31'd0, oError}, 32'd0);
        send(8'h00); send(8'h01);
        send(8'h0A); send(8'hBC); send(8'hDE);
        iByteValid = 1'b0;
        repeat (T - 1) tick();
        chk("tmo_early", {31'd0, oError}, 32'd0);
        tick();
        chk_outs("tmo", 1'b1, 1'b0, 1'b1);
        tick();
        chk("tmo_writes", 32'(wr_cnt - base), 32'd0);

        // Gapped stream, upper nibble of byte0 set
        base = wr_cnt;
        start();
        send_gap(8'h00); send_gap(8'h02);
        send_gap(8'hFA); send_gap(8'h12); send_gap(8'h34); send_gap(8'h56);
        send_gap(8'hF1); send_gap(8'h00); send_gap(8'h00); send_gap(8'h05);
        iByteValid = 1'b0;
        tick();
        chk_outs("gap", 1'b0, 1'b1, 1'b0);
        chk("gap_writes", 32'(wr_cnt - base), 32'd2);
        chk("gap_a0", 32'(log_addr[base]), 32'd0);
        chk("gap_d0", 32'(log_data[base]), 32'h0A123456);
        chk("gap_a1", 32'(log_addr[base + 1]), 32'd1);
        chk("gap_d1", 32'(log_data[base + 1]), 32'h01000005);

        // Reset after two of three words
        base = wr_cnt;
        start();
        send(8'h00); send(8'h03);
        send(8'h01); send(8'h11); send(8'h11); send(8'h11);
        send(8'h02); send(8'h22); send(8'h22); send(8'h22);
        send(8'h03); send(8'h33); send(8'h33);
        iByte = 8'h33;
        Reset = 1'b1;
        tick();
        chk_outs("midrst", 1'b1, 1'b0, 1'b0);
        chk("midrst_ready", {31'd0, oByteReady}, 32'd0);
        chk("midrst_we", {31'd0, oWriteEnable}, 32'd0);
        chk("midrst_addr", 32'(oWriteAddress), 32'd0);
        chk("midrst_data", 32'(oWriteData), 32'd0);
        Reset = 1'b0;
        iByteValid = 1'b0;
        repeat (3) tick();
        chk("midrst_writes", 32'(wr_cnt - base), 32'd2);

        // Full reload after the mid-load reset
        base = wr_cnt;
        start();
        send(8'h00); send(8'h03);
        send(8'h01); send(8'h11); send(8'h11); send(8'h11);
        send(8'h02); send(8'h22); send(8'h22); send(8'h22);
        send(8'h03); send(8'h33); send(8'h33); send(8'h33);
        iByteValid = 1'b0;
        tick();
        chk_outs("reload", 1'b0, 1'b1, 1'b0);
        chk("reload_writes", 32'(wr_cnt - base), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("reload_addr", 32'(log_addr[base + i]), 32'(i));
            chk("reload_data", 32'(log_data[base + i]), 32'h01111111 * (i + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction-memory interface. The MiniAlu-style core reads 28-bit instructions by address; this block produces them.
- Receives a byte stream over a valid/ready handshake, assembles 28-bit instruction words and writes them sequentially into a writable instruction RAM starting at address 0.
- Holds the core in reset until a complete program has loaded.
- Sits between a host byte source (UART receiver or switch interface) and the instruction RAM write port.

Parameters:
- ADDR_WIDTH, 10, instruction RAM address width; maximum program length is 2**ADDR_WIDTH words.
- TIMEOUT_CYCLES, 1000, maximum number of cycles allowed between accepted bytes while receiving.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- iStart  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- iByte  input  8  incoming stream byte.
- iByteValid  input  1  iByte is valid.
- oByteReady  output  1  loader can accept a byte this cycle.
- oWriteEnable  output  1  instruction RAM write strobe, one cycle per word.
- oWriteAddress  output  ADDR_WIDTH  instruction RAM write address.
- oWriteData  output  28  instruction word.
- oCpuReset  output  1  hold-reset to the core.
- oDone  output  1  program loaded successfully.
- oError  output  1  load aborted.

Behaviour:
- Handshake: a byte is accepted on a rising edge where iByteValid=1 and oByteReady=1. oByteReady=1 only in LEN_HI, LEN_LO and DATA.
- Stream format, big-endian throughout:
  - 2 bytes: word count N.
  - Then N words of 4 bytes each, MSB first.
  - Word = {byte0[3:0], byte1, byte2, byte3}; byte0[7:4] is ignored.
- IDLE (reset state): oCpuReset=1; oDone, oError, oWriteEnable and oByteReady are 0; oWriteAddress=0; oWriteData=0. iStart moves to LEN_HI and clears the word index and timeout counter.
- LEN_HI: an accepted byte gives N[15:8]; go to LEN_LO.
- LEN_LO: an accepted byte gives N[7:0].
  - N=0: go to DONE.
  - N>2**ADDR_WIDTH: go to ERROR.
  - Otherwise: go to DATA with byte counter 0.
- DATA: each accepted byte shifts into the 28-bit assembly register and increments the 2-bit byte counter. Acceptance of the 4th byte moves to WRITE.
- WRITE: exactly one cycle.
  - Drives oWriteEnable=1, oWriteAddress=word index, oWriteData=assembled word; oByteReady=0.
  - If word index = N-1, go to DONE.
  - Otherwise increment word index, clear byte counter and return to DATA.
  - Latency from acceptance of the 4th byte to the write strobe: exactly 1 cycle.
- DONE: oDone=1 and oCpuReset=0. The first cycle with oCpuReset=0 is the cycle after the last WRITE. Stays here until iStart, which re-enters LEN_HI, reasserts oCpuReset and clears oDone.
- ERROR: oError=1 and oCpuReset=1. Stays here until iStart, which behaves as in DONE.
- Timeout:
  - Counter clears on every accepted byte and on entry to LEN_HI.
  - It increments each cycle in LEN_HI, LEN_LO or DATA when no byte is accepted.
  - On reaching TIMEOUT_CYCLES, go to ERROR; the partially assembled word is never written.
- Writes already performed before an ERROR remain in RAM; the loader does not clear RAM.
- iStart is ignored in LEN_HI, LEN_LO, DATA and WRITE.
- Reset mid-load: on the next edge return to IDLE with all outputs at reset values; no further write strobes.
- oWriteAddress and oWriteData hold their last values outside WRITE. Only oWriteEnable qualifies them.
- Back-to-back bytes (iByteValid held high) are accepted at 1 byte/cycle except during the WRITE cycle. A full word therefore takes 5 cycles.

Test Plan:
- Reset, then iStart, then stream 00 02 | 0A 12 34 56 | 01 00 00 05 with valid held high -> writes 0xA123456 @0 and 0x1000005 @1, one cycle each; oDone=1 and oCpuReset=0 the cycle after the 2nd write.
- iStart, then stream 00 00 -> DONE with no oWriteEnable pulse.
- ADDR_WIDTH=10, stream 04 01 (N=1025) -> ERROR after the 2nd byte; oCpuReset stays 1; no writes.
- N=1, then 3 data bytes followed by TIMEOUT_CYCLES idle cycles -> oError=1 exactly on the timeout; no write.
- Drop iByteValid for random gaps shorter than the timeout, byte0 upper nibble = F -> same RAM contents as the gap-free stream; upper nibble ignored.
- Assert Reset after 2 of 3 words written -> IDLE next edge, oCpuReset=1, no 3rd write; a subsequent iStart plus full stream loads correctly.
